// File: rtl/demux8_collector.sv
// demux8_collector
//   Collects a stream of scalar real samples into an eight-lane row. Each
//   accepted sample is written into one lane. Once every lane has been
//   written, the row is presented on out0..out7 with out_valid and held
//   until the consumer takes it with out_ready.
//
// Configuration
//   HOLD_CLEAR              1: zero all lanes when a held row is released,
//                           0: lanes keep their values across rows.
//   DEMUX8_EXPLICIT_SEL_EN  (macro) when defined, in_sel picks the lane and
//                           rewrites to a lane that is already written do
//                           not count again. When undefined, an internal
//                           3-bit counter picks lanes 0..7 in order and
//                           in_sel is ignored.
//
// Ports
//   clk         clock, all state on the rising edge
//   rst         synchronous active-high reset
//   in_data     real sample offered upstream
//   in_sel      target lane (explicit-select build only)
//   in_valid    upstream offers in_data
//   in_ready    block accepts in_data this cycle (from state and rst only)
//   out0..out7  registered lane values
//   out_valid   registered, full row stable on the outputs
//   out_ready   downstream consumes the held row
//   fill_count  registered number of distinct lanes written (0..8)

module demux8_collector #(
  parameter bit HOLD_CLEAR = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  real        in_data,
  input  logic [2:0] in_sel,
  input  logic       in_valid,
  output logic       in_ready,
  output real        out0,
  output real        out1,
  output real        out2,
  output real        out3,
  output real        out4,
  output real        out5,
  output real        out6,
  output real        out7,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] fill_count
);

  localparam int unsigned NumLanes = 8;
  localparam int unsigned IdxW     = 3;
  localparam int unsigned CountW   = 4;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [NumLanes-1:0]   mask_q, mask_d;
  logic [CountW-1:0]     fill_q, fill_d;
  logic                  valid_q, valid_d;
  real                   lane_q [NumLanes];
  real                   lane_d [NumLanes];
  logic [IdxW-1:0]       idx;
  logic                  accept;

  // Number of set bits in the written mask.
  function automatic logic [CountW-1:0] popcnt8(input logic [NumLanes-1:0] m);
    logic [CountW-1:0] c;
    c = '0;
    for (int i = 0; i < int'(NumLanes); i++) begin
      c = c + CountW'(m[i]);
    end
    return c;
  endfunction

  // Lane select: explicit index or an in-order write pointer.
`ifdef DEMUX8_EXPLICIT_SEL_EN
  assign idx = in_sel;
`else
  logic [IdxW-1:0] cnt_q, cnt_d;
  logic            sel_unused;

  assign idx        = cnt_q;
  assign sel_unused = ^in_sel;
`endif

  // Ready depends only on state; held low while reset is asserted.
  assign in_ready = (state_q == FILL) & ~rst;
  assign accept   = in_valid & in_ready;

  // Next-state and lane update.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    valid_d = valid_q;
    for (int i = 0; i < int'(NumLanes); i++) begin
      lane_d[i] = lane_q[i];
    end
`ifndef DEMUX8_EXPLICIT_SEL_EN
    cnt_d = cnt_q;
`endif

    case (state_q)
      FILL: begin
        if (accept) begin
          lane_d[idx] = in_data;
          mask_d[idx] = 1'b1;
`ifndef DEMUX8_EXPLICIT_SEL_EN
          cnt_d = cnt_q + IdxW'(1);
`endif
          // Row completes on the edge the last missing lane is written.
          if (&mask_d) begin
            state_d = HOLD;
            valid_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = FILL;
          mask_d  = '0;
          valid_d = 1'b0;
`ifndef DEMUX8_EXPLICIT_SEL_EN
          cnt_d = '0;
`endif
          if (HOLD_CLEAR) begin
            for (int i = 0; i < int'(NumLanes); i++) begin
              lane_d[i] = 0.0;
            end
          end
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase

    fill_d = popcnt8(mask_d);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      mask_q  <= '0;
      fill_q  <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < int'(NumLanes); i++) begin
        lane_q[i] <= 0.0;
      end
`ifndef DEMUX8_EXPLICIT_SEL_EN
      cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      fill_q  <= fill_d;
      valid_q <= valid_d;
      for (int i = 0; i < int'(NumLanes); i++) begin
        lane_q[i] <= lane_d[i];
      end
`ifndef DEMUX8_EXPLICIT_SEL_EN
      cnt_q <= cnt_d;
`endif
    end
  end

  assign out_valid  = valid_q;
  assign fill_count = fill_q;
  assign out0       = lane_q[0];
  assign out1       = lane_q[1];
  assign out2       = lane_q[2];
  assign out3       = lane_q[3];
  assign out4       = lane_q[4];
  assign out5       = lane_q[5];
  assign out6       = lane_q[6];
  assign out7       = lane_q[7];

endmodule

// File: tb/tb_demux8_collector.sv
// Bench for demux8_collector: two instances (lanes retained / lanes cleared
// on release) share one stimulus stream; a reference model predicts handshake,
// count and lane values, and completed rows go through a scoreboard queue.
module tb_demux8_collector;

  logic       clk = 1'b0;
  logic       rst;
  real        in_data;
  logic [2:0] in_sel;
  logic       in_valid;
  logic       out_ready;

  logic       rdy_a, rdy_b;
  logic       ov_a, ov_b;
  logic [3:0] fc_a, fc_b;
  real        oa [8];
  real        ob [8];

  int n_assert = 0;
  int n_fail   = 0;

  // reference model
  logic       m_hold;
  logic [7:0] m_mask;
  logic [2:0] m_cnt;
  real        m_lane_a [8];
  real        m_lane_b [8];
  real        sb_q [$];

  always #5 clk = ~clk;

  demux8_collector #(.HOLD_CLEAR(1'b0)) u_ret (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(rdy_a),
    .out0(oa[0]), .out1(oa[1]), .out2(oa[2]), .out3(oa[3]),
    .out4(oa[4]), .out5(oa[5]), .out6(oa[6]), .out7(oa[7]),
    .out_valid(ov_a), .out_ready(out_ready), .fill_count(fc_a)
  );

  demux8_collector #(.HOLD_CLEAR(1'b1)) u_clr (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(rdy_b),
    .out0(ob[0]), .out1(ob[1]), .out2(ob[2]), .out3(ob[3]),
    .out4(ob[4]), .out5(ob[5]), .out6(ob[6]), .out7(ob[7]),
    .out_valid(ov_b), .out_ready(out_ready), .fill_count(fc_b)
  );

  function automatic logic [3:0] pop8(input logic [7:0] m);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + 4'(m[i]);
    return c;
  endfunction

  task automatic chk_bits(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_real(input string tag, input real obs, input real exp);
    n_assert++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s observed=%f expected=%f at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_lanes();
    for (int i = 0; i < 8; i++) begin
      chk_real($sformatf("lane_ret[%0d]", i), oa[i], m_lane_a[i]);
      chk_real($sformatf("lane_clr[%0d]", i), ob[i], m_lane_b[i]);
    end
  endtask

  // One clock: drive at negedge, check ready, advance model, check after edge.
  task automatic cyc(input logic v, input real d, input logic [2:0] s,
                     input logic r, input logic rs);
    logic       was_hold;
    logic       acc;
    logic [2:0] idx;
    rst       = rs;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
`ifdef DEMUX8_EXPLICIT_SEL_EN
    in_sel = s;
    idx    = s;
`else
    in_sel = 3'($urandom_range(0, 7));
    idx    = m_cnt;
`endif
    #1;
    chk_bits("in_ready_ret", 4'(rdy_a), rs ? 4'd0 : 4'(!m_hold));
    chk_bits("in_ready_clr", 4'(rdy_b), rs ? 4'd0 : 4'(!m_hold));

    was_hold = m_hold;
    acc      = v && !m_hold && !rs;
    if (rs) begin
      m_hold = 1'b0; m_mask = '0; m_cnt = '0;
      for (int i = 0; i < 8; i++) begin m_lane_a[i] = 0.0; m_lane_b[i] = 0.0; end
    end else if (acc) begin
      m_lane_a[idx] = d;
      m_lane_b[idx] = d;
      m_mask[idx]   = 1'b1;
      m_cnt         = m_cnt + 3'd1;
      if (m_mask == 8'hFF) begin
        m_hold = 1'b1;
        for (int i = 0; i < 8; i++) sb_q.push_back(m_lane_a[i]);
      end
    end else if (m_hold && r) begin
      m_hold = 1'b0; m_mask = '0; m_cnt = '0;
      for (int i = 0; i < 8; i++) m_lane_b[i] = 0.0;
    end

    @(posedge clk);
    @(negedge clk);
    chk_bits("out_valid_ret", 4'(ov_a), 4'(m_hold));
    chk_bits("out_valid_clr", 4'(ov_b), 4'(m_hold));
    chk_bits("fill_count_ret", fc_a, pop8(m_mask));
    chk_bits("fill_count_clr", fc_b, pop8(m_mask));
    chk_lanes();
    // A new row on the outputs is scored against the queued expectation.
    if (m_hold && !was_hold) begin
      n_assert++;
      assert (sb_q.size() >= 8) else begin
        n_fail++;
        $error("FAIL scoreboard_empty observed=%0d expected=8", sb_q.size());
      end
      if (sb_q.size() >= 8) begin
        for (int i = 0; i < 8; i++) chk_real($sformatf("row_lane[%0d]", i), oa[i], sb_q.pop_front());
      end
    end
  endtask

  initial begin
    m_hold = 1'b0; m_mask = '0; m_cnt = '0;
    for (int i = 0; i < 8; i++) begin m_lane_a[i] = 0.0; m_lane_b[i] = 0.0; end
    rst = 1'b1; in_valid = 1'b0; in_data = 0.0; in_sel = '0; out_ready = 1'b0;
    @(negedge clk);

    // reset for 2 cycles with traffic offered; reset has priority
    cyc(1'b1, 42.0, 3'd0, 1'b1, 1'b1);
    cyc(1'b1, 43.0, 3'd0, 1'b1, 1'b1);

    // sequential fill 1.0..8.0, then 5 cycles of backpressure with traffic offered
    for (int i = 0; i < 8; i++) cyc(1'b1, real'(i + 1), m_cnt, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 99.0, 3'd5, 1'b0, 1'b0);
    // release: no accept in the release cycle
    cyc(1'b1, 77.0, 3'd2, 1'b1, 1'b0);

    // gaps: in_valid toggles over 16 cycles, out_ready high but ignored in FILL
    for (int i = 0; i < 16; i++) begin
      if (i == 15) cyc(1'b0, 0.0, m_cnt, 1'b0, 1'b0);
      else cyc(logic'(i % 2 == 0), real'(10 + i), m_cnt, 1'b1, 1'b0);
    end
    cyc(1'b0, 0.0, 3'd0, 1'b1, 1'b0);

    // reset mid-row: 5 accepts, reset, then a full fresh row is required
    for (int i = 0; i < 5; i++) cyc(1'b1, real'(100 + i), m_cnt, 1'b0, 1'b0);
    cyc(1'b1, 55.0, 3'd0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) cyc(1'b1, real'(200 + i) + 0.5, m_cnt, 1'b0, 1'b0);
    cyc(1'b0, 0.0, 3'd0, 1'b1, 1'b0);

`ifdef DEMUX8_EXPLICIT_SEL_EN
    // explicit select: lane 3 rewritten, nine accepts for a full row
    begin
      logic [2:0] sels [9];
      real        vals [9];
      sels = '{3'd3, 3'd3, 3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7};
      vals = '{9.0, 2.5, 1.0, 2.0, 3.0, 5.0, 6.0, 7.0, 8.0};
      for (int i = 0; i < 9; i++) cyc(1'b1, vals[i], sels[i], 1'b0, 1'b0);
      chk_real("explicit_out3", oa[3], 2.5);
      cyc(1'b0, 0.0, 3'd0, 1'b1, 1'b0);
    end
`endif

    // reset while holding a row: discarded without out_valid
    for (int i = 0; i < 8; i++) cyc(1'b1, real'(i) * 0.25, m_cnt, 1'b0, 1'b0);
    cyc(1'b0, 0.0, 3'd0, 1'b0, 1'b1);
    cyc(1'b0, 0.0, 3'd0, 1'b0, 1'b0);

    n_assert++;
    assert (sb_q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/demux8_collector.md
DEMUX8_COLLECTOR -- requirements
Module: demux8_collector

Interface
REQ-001 SHALL have parameter HOLD_CLEAR, default 0, meaning: 1 = clear all lane registers to 0.0 on leaving HOLD, 0 = lanes retain their values.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset sampled on the rising edge of clk.
REQ-004 SHALL have port in_data, input, real, the scalar float value to be distributed.
REQ-005 SHALL have port in_sel, input, 3, the target lane index; used only when DEMUX8_EXPLICIT_SEL_EN is defined.
REQ-006 SHALL have port in_valid, input, 1, upstream offers in_data.
REQ-007 SHALL have port in_ready, output, 1, block accepts in_data this cycle.
REQ-008 SHALL have ports out0..out7, output, real each, registered lane values.
REQ-009 SHALL have port out_valid, output, 1, all eight lanes written and row stable.
REQ-010 SHALL have port out_ready, input, 1, downstream consumes the row.
REQ-011 SHALL have port fill_count, output, 4, number of distinct lanes written in the current row (0..8).

Function
REQ-012 SHALL implement a two-state FSM: FILL and HOLD.
REQ-013 SHALL drive in_ready=1 in FILL and in_ready=0 in HOLD and during reset; in_ready SHALL be combinational from state only, with no dependency on in_valid.
REQ-014 SHALL accept a write when in_valid && in_ready, storing in_data into lane idx on that edge.
REQ-015 SHALL set written-mask bit idx on accept; fill_count SHALL equal the popcount of the mask, registered.
REQ-016 SHALL move FILL->HOLD on the edge where the mask becomes all ones, so out_valid=1 in the cycle after the eighth distinct-lane accept (latency 1).
REQ-017 SHALL hold out0..out7 and out_valid stable in HOLD until out_ready=1.
REQ-018 SHALL, on out_ready=1 in HOLD, clear the mask, drive fill_count to 0 and out_valid to 0 on the next cycle, and return to FILL; lanes SHALL be cleared to 0.0 if HOLD_CLEAR=1, otherwise retained.
REQ-019 SHALL ignore out_ready in FILL.
REQ-020 SHALL perform no accept in the cycle that HOLD->FILL is taken, because in_ready is 0 in HOLD; the first new accept occurs no earlier than the following cycle.
REQ-021 SHALL update out0..out7 only on accepted writes, on reset, or on HOLD exit with HOLD_CLEAR=1.

Reset
REQ-022 SHALL, while rst=1 at a clock edge, set state=FILL, out0..out7=0.0, out_valid=0, fill_count=0, mask=0 and the lane counter=0.
REQ-023 SHALL let reset mid-row or in HOLD discard the partial or complete row without emitting out_valid.
REQ-024 SHALL give rst priority over any simultaneous in_valid or out_ready.

Configuration
REQ-025 SHALL, when macro DEMUX8_EXPLICIT_SEL_EN is defined, take idx=in_sel; a repeated write to an already-set lane SHALL overwrite the value without incrementing fill_count.
REQ-026 SHALL, when DEMUX8_EXPLICIT_SEL_EN is undefined, take idx from an internal 3-bit counter that starts at 0, increments on each accept, and wraps 7->0 on the eighth accept; in_sel SHALL be ignored.

Verification
REQ-027 SHALL cover reset: rst=1 for 2 cycles -> outputs 0.0, out_valid=0, fill_count=0, in_ready=0 during rst and 1 after.
REQ-028 SHALL cover sequential fill (macro off): values 1.0..8.0 with in_valid held high -> out0=1.0..out7=8.0, out_valid=1 one cycle after the eighth accept, in_ready=0.
REQ-029 SHALL cover backpressure: out_ready=0 for 5 cycles in HOLD -> outputs unchanged and no accept; out_ready=1 -> FILL next cycle, fill_count=0, retained lanes when HOLD_CLEAR=0, all 0.0 when HOLD_CLEAR=1.
REQ-030 SHALL cover explicit select (macro on): writes sel 3,3,0,1,2,4,5,6,7 with values 9.0 then 2.5 on lane 3 -> out3=2.5, out_valid after the ninth accept, fill_count never exceeds 8.
REQ-031 SHALL cover reset mid-row: rst after 5 accepts -> fill_count=0, no out_valid, and the next 8 accepts are required to complete a row.
REQ-032 SHALL cover gaps: in_valid toggled 1,0,1,0 across 16 cycles -> exactly 8 accepts, with out_valid only after the eighth.
